intel_fpga_apb_csr: RTL and testbench
=====================================

// Module: intel_fpga_apb_csr
// PURPOSE
// - APB3 completer holding the subsystem control/status registers. It sits directly downstream of
//   intel_fpga_axil2apb and connects port-for-port to its m_apb_* outputs.
// - Provides ID, scratch, control and status registers, an edge-latched W1C interrupt block and a
//   64-bit cycle counter read coherently through a snapshot.
// - Inserts programmable wait states so the upstream bridge's watchdog path can be exercised.
// PARAMETERS
// - P_ADDR_WIDTH    8             APB byte-address width, >= 5.
// - P_DATA_WIDTH    32            APB data width. Fixed at 32.
// - P_ID            32'h0A5B_0001 Value returned by the ID register.
// - P_CTRL_WIDTH    16            Implemented CONTROL bits. Upper bits read 0.
// - P_IRQ_WIDTH     8             Number of interrupt sources, <= 32.
// - P_WAIT_STATES   0             Access-phase cycles with PREADY low, 0..255.
// - P_ERR_EN        1             1: unmapped access completes with PSLVERR=1.
// PORTS
// - s_apb_pclk     in   1               Clock. Single domain.
// - s_apb_presetn  in   1               Reset. Asynchronous, active-low.
// - s_apb_paddr    in   P_ADDR_WIDTH    Byte address. Bits [1:0] are ignored.
// - s_apb_psel     in   1               Select.
// - s_apb_penable  in   1               Access phase.
// - s_apb_pwrite   in   1               1=write, 0=read.
// - s_apb_pwdata   in   32              Write data.
// - s_apb_prdata   out  32              Read data. Valid when PREADY=1 in the access phase.
// - s_apb_pready   out  1               Transfer complete.
// - s_apb_pslverr  out  1               Error. Valid with PREADY.
// - ctrl_o         out  P_CTRL_WIDTH    CONTROL register contents.
// - status_i       in   32              Live status. Sampled at read completion.
// - irq_src_i      in   P_IRQ_WIDTH     Interrupt sources, synchronous to s_apb_pclk. Rising-edge sensitive.
// - irq_o          out  1               Registered OR of (pending & enable).
// BEHAVIOUR
// - Reset values: every flop resets asynchronously.
//   - pready=0, pslverr=0, prdata=0, ctrl_o=0, irq_o=0.
//   - SCRATCH=0, IRQ_EN=0, IRQ_PEND=0, counter=0, snapshot=0.
//   - Edge-detect history is set to 0.
// - Handshake:
//   - Setup phase is psel & ~penable. It clears the wait counter.
//   - In the access phase (psel & penable), the wait counter increments until it reaches P_WAIT_STATES.
//   - pready = psel & penable & (wcnt == P_WAIT_STATES). This is combinational from the counter,
//     so P_WAIT_STATES=0 completes in the first access cycle.
//   - Outside a completing access cycle: prdata=0, pslverr=0.
//   - Write side effects take place only in the completion cycle (psel & penable & pready & pwrite).
// - Register map (byte offset, access):
//   - 0x00 ID RO: reads P_ID.
//   - 0x04 SCRATCH RW.
//   - 0x08 CONTROL RW: bits [P_CTRL_WIDTH-1:0].
//   - 0x0C STATUS RO: returns status_i.
//   - 0x10 IRQ_PEND W1C.
//   - 0x14 IRQ_EN RW.
//   - 0x18 CYCLE_LO RO.
//   - 0x1C CYCLE_HI RO: returns the snapshot.
//   - Writes to RO registers are ignored with pslverr=0.
//   - Other offsets read 0, ignore writes, and complete with pslverr=P_ERR_EN.
// - Cycle counter:
//   - 64-bit free-running counter, +1 every clock, wraps from 2^64-1 to 0.
//   - A CYCLE_LO read completion returns cnt[31:0] and loads snapshot <= cnt[63:32] in the same cycle.
//   - CYCLE_HI returns the snapshot and has no side effects.
// - Interrupts:
//   - pend[i] is set on the rising edge irq_src_i[i] & ~irq_src_q[i].
//   - pend[i] is cleared by a write of 1 to IRQ_PEND bit i.
//   - A set and a clear of the same bit in the same cycle: set wins.
//   - irq_o is registered from |(pend & en): 1-cycle latency from a pend/en change.
// - PSEL dropped mid-access (protocol violation): the wait counter restarts at the next setup phase,
//   and no side effect occurs.
// - Reset asserted mid-transfer: outputs are forced to reset values immediately. The upstream
//   bridge's watchdog recovers its own state.
// STRUCTURE
// - Package intel_fpga_apb_csr_pkg holds:
//   - Offset localparams (CSR_ID .. CSR_CYCLE_HI).
//   - A typedef enum for the register index decoded from paddr[4:2].
//   - The P_ID default constant.
// - Sub-module intel_fpga_apb_csr_irq holds the edge detect, W1C pending, enable register and
//   irq_o flop.
// - The top level keeps the decode, wait counter, counter/snapshot and read mux.
// TESTING
// - Write 0xDEADBEEF to 0x04, read 0x04, with P_WAIT_STATES=0.
//   -> Each transfer completes 2 cycles after psel rises, and the read returns 0xDEADBEEF.
// - P_WAIT_STATES=3: read 0x00.
//   -> pready low for 3 access cycles, high on the 4th; prdata=0x0A5B0001; pslverr=0.
// - Enable IRQ_EN=0x01, pulse irq_src_i[0].
//   -> IRQ_PEND reads 0x01 and irq_o=1 one cycle after pend sets.
//   -> Write 0x01 to 0x10 while irq_src_i[0] rises in the completion cycle: pend stays 1 and irq_o stays 1.
// - Preload the counter to 0x0000_0000_FFFF_FFFF (force), read 0x18 at that value, then read 0x1C.
//   -> CYCLE_LO returns 0xFFFFFFFF and CYCLE_HI returns 0x00000000 despite the rollover between reads.
// - Read 0x40 with P_ERR_EN=1. -> prdata=0, pslverr=1. Write 0x40. -> pslverr=1 and no state changes.
// - Assert s_apb_presetn low during the access phase of a CONTROL write.
//   -> ctrl_o=0 and pready=0 immediately. A post-reset read of CONTROL returns 0.

Source files
------------

// File: rtl/intel_fpga_apb_csr_pkg.sv
// CSR block shared definitions.
// Register offsets, decoded index and default ID.
package intel_fpga_apb_csr_pkg;

  localparam logic [31:0] CSR_ID_DEFAULT = 32'h0A5B_0001;

  localparam logic [7:0] CSR_ID       = 8'h00;
  localparam logic [7:0] CSR_SCRATCH  = 8'h04;
  localparam logic [7:0] CSR_CONTROL  = 8'h08;
  localparam logic [7:0] CSR_STATUS   = 8'h0C;
  localparam logic [7:0] CSR_IRQ_PEND = 8'h10;
  localparam logic [7:0] CSR_IRQ_EN   = 8'h14;
  localparam logic [7:0] CSR_CYCLE_LO = 8'h18;
  localparam logic [7:0] CSR_CYCLE_HI = 8'h1C;

  typedef enum logic [2:0] {
    IDX_ID      = CSR_ID[4:2],
    IDX_SCRATCH = CSR_SCRATCH[4:2],
    IDX_CTRL    = CSR_CONTROL[4:2],
    IDX_STATUS  = CSR_STATUS[4:2],
    IDX_PEND    = CSR_IRQ_PEND[4:2],
    IDX_EN      = CSR_IRQ_EN[4:2],
    IDX_CYC_LO  = CSR_CYCLE_LO[4:2],
    IDX_CYC_HI  = CSR_CYCLE_HI[4:2]
  } csr_idx_e;

  function automatic csr_idx_e csr_idx(input logic [2:0] w);
    return csr_idx_e'(w);
  endfunction

endpackage

// File: rtl/intel_fpga_apb_csr_irq.sv
// Interrupt block: edge detect, W1C pending,
// enable register and registered irq output.
module intel_fpga_apb_csr_irq #(
  parameter int unsigned P_IRQ_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [P_IRQ_WIDTH-1:0] src_i,
  input  logic                   en_we_i,
  input  logic                   pend_w1c_i,
  input  logic [P_IRQ_WIDTH-1:0] wdata_i,
  output logic [P_IRQ_WIDTH-1:0] pend_o,
  output logic [P_IRQ_WIDTH-1:0] en_o,
  output logic                   irq_o
);

  logic [P_IRQ_WIDTH-1:0] src_q;
  logic [P_IRQ_WIDTH-1:0] pend_q, pend_d;
  logic [P_IRQ_WIDTH-1:0] en_q, en_d;
  logic [P_IRQ_WIDTH-1:0] clr;
  logic                   irq_q, irq_d;

  // Next state: a new rising edge overrides a same-cycle clear.
  always_comb begin
    clr    = pend_w1c_i ? wdata_i : '0;
    pend_d = (pend_q & ~clr) | (src_i & ~src_q);
    en_d   = en_we_i ? wdata_i : en_q;
    irq_d  = |(pend_q & en_q);
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q  <= '0;
      pend_q <= '0;
      en_q   <= '0;
      irq_q  <= 1'b0;
    end else begin
      src_q  <= src_i;
      pend_q <= pend_d;
      en_q   <= en_d;
      irq_q  <= irq_d;
    end
  end

  assign pend_o = pend_q;
  assign en_o   = en_q;
  assign irq_o  = irq_q;

endmodule

// File: rtl/intel_fpga_apb_csr.sv
// APB3 control/status register completer with
// wait states, W1C interrupts and cycle counter.
module intel_fpga_apb_csr
  import intel_fpga_apb_csr_pkg::*;
#(
  parameter int unsigned P_ADDR_WIDTH  = 8,
  parameter int unsigned P_DATA_WIDTH  = 32,
  parameter logic [31:0] P_ID          = CSR_ID_DEFAULT,
  parameter int unsigned P_CTRL_WIDTH  = 16,
  parameter int unsigned P_IRQ_WIDTH   = 8,
  parameter int unsigned P_WAIT_STATES = 0,
  parameter bit          P_ERR_EN      = 1'b1
) (
  input  logic                    s_apb_pclk,
  input  logic                    s_apb_presetn,
  input  logic [P_ADDR_WIDTH-1:0] s_apb_paddr,
  input  logic                    s_apb_psel,
  input  logic                    s_apb_penable,
  input  logic                    s_apb_pwrite,
  input  logic [P_DATA_WIDTH-1:0] s_apb_pwdata,
  output logic [P_DATA_WIDTH-1:0] s_apb_prdata,
  output logic                    s_apb_pready,
  output logic                    s_apb_pslverr,
  output logic [P_CTRL_WIDTH-1:0] ctrl_o,
  input  logic [31:0]             status_i,
  input  logic [P_IRQ_WIDTH-1:0]  irq_src_i,
  output logic                    irq_o
);

  localparam logic [7:0] WAIT = 8'(P_WAIT_STATES);

  logic                    setup, access, done;
  logic                    mapped, wr_hit, rd_hit;
  csr_idx_e                idx;
  logic [7:0]              wcnt_q, wcnt_d;
  logic [P_DATA_WIDTH-1:0] scratch_q, scratch_d;
  logic [P_CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [63:0]             cnt_q;
  logic [31:0]             snap_q, snap_d;
  logic [P_IRQ_WIDTH-1:0]  pend, en;
  logic [P_DATA_WIDTH-1:0] rd_val;
  logic                    rd_err;
  logic                    unused_addr;

  assign unused_addr = ^s_apb_paddr[1:0];

  assign setup  = s_apb_psel & ~s_apb_penable;
  assign access = s_apb_psel & s_apb_penable;
  // Reset gates completion so a held access
  // never reports ready while in reset.
  assign done   = s_apb_presetn & access & (wcnt_q == WAIT);
  assign mapped = (s_apb_paddr >> 5) == '0;
  assign idx    = csr_idx(s_apb_paddr[4:2]);
  assign wr_hit = done & s_apb_pwrite & mapped;
  assign rd_hit = done & ~s_apb_pwrite & mapped;

  // Next state for wait counter and RW registers.
  always_comb begin
    wcnt_d    = wcnt_q;
    scratch_d = scratch_q;
    ctrl_d    = ctrl_q;
    snap_d    = snap_q;
    if (setup) begin
      wcnt_d = '0;
    end else if (access && wcnt_q != WAIT) begin
      wcnt_d = wcnt_q + 8'd1;
    end
    if (wr_hit && idx == IDX_SCRATCH) begin
      scratch_d = s_apb_pwdata;
    end
    if (wr_hit && idx == IDX_CTRL) begin
      ctrl_d = s_apb_pwdata[P_CTRL_WIDTH-1:0];
    end
    if (rd_hit && idx == IDX_CYC_LO) begin
      snap_d = cnt_q[63:32];
    end
  end

  // State registers and free-running counter.
  always_ff @(posedge s_apb_pclk or negedge s_apb_presetn) begin
    if (!s_apb_presetn) begin
      wcnt_q    <= '0;
      scratch_q <= '0;
      ctrl_q    <= '0;
      cnt_q     <= '0;
      snap_q    <= '0;
    end else begin
      wcnt_q    <= wcnt_d;
      scratch_q <= scratch_d;
      ctrl_q    <= ctrl_d;
      cnt_q     <= cnt_q + 64'd1;
      snap_q    <= snap_d;
    end
  end

  // Read mux and error decode.
  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    if (!mapped) begin
      rd_err = P_ERR_EN;
    end else begin
      unique case (idx)
        IDX_ID:      rd_val = P_DATA_WIDTH'(P_ID);
        IDX_SCRATCH: rd_val = scratch_q;
        IDX_CTRL:    rd_val = P_DATA_WIDTH'(ctrl_q);
        IDX_STATUS:  rd_val = P_DATA_WIDTH'(status_i);
        IDX_PEND:    rd_val = P_DATA_WIDTH'(pend);
        IDX_EN:      rd_val = P_DATA_WIDTH'(en);
        IDX_CYC_LO:  rd_val = P_DATA_WIDTH'(cnt_q[31:0]);
        IDX_CYC_HI:  rd_val = P_DATA_WIDTH'(snap_q);
      endcase
    end
  end

  assign s_apb_pready  = done;
  assign s_apb_prdata  = (done & ~s_apb_pwrite) ? rd_val : '0;
  assign s_apb_pslverr = done & rd_err;
  assign ctrl_o        = ctrl_q;

  intel_fpga_apb_csr_irq #(
    .P_IRQ_WIDTH(P_IRQ_WIDTH)
  ) u_irq (
    .clk_i      (s_apb_pclk),
    .rst_ni     (s_apb_presetn),
    .src_i      (irq_src_i),
    .en_we_i    (wr_hit & (idx == IDX_EN)),
    .pend_w1c_i (wr_hit & (idx == IDX_PEND)),
    .wdata_i    (s_apb_pwdata[P_IRQ_WIDTH-1:0]),
    .pend_o     (pend),
    .en_o       (en),
    .irq_o      (irq_o)
  );

endmodule

// File: tb/tb_intel_fpga_apb_csr.sv
// Bench for the APB CSR block: directed steps
// plus randomized traffic against a register model.
module tb_intel_fpga_apb_csr;

  logic        clk;
  logic        rst_n;
  logic        psel[2];
  logic        penable[2];
  logic        pwrite[2];
  logic [7:0]  paddr[2];
  logic [31:0] pwdata[2];
  logic [31:0] prdata[2];
  logic        pready[2];
  logic        pslverr[2];
  logic [15:0] ctrl[2];
  logic        irq[2];
  logic [31:0] status;
  logic [7:0]  irq_src;

  int n_chk;
  int n_fail;

  intel_fpga_apb_csr #(.P_WAIT_STATES(0)) u_dut0 (
    .s_apb_pclk    (clk),
    .s_apb_presetn (rst_n),
    .s_apb_paddr   (paddr[0]),
    .s_apb_psel    (psel[0]),
    .s_apb_penable (penable[0]),
    .s_apb_pwrite  (pwrite[0]),
    .s_apb_pwdata  (pwdata[0]),
    .s_apb_prdata  (prdata[0]),
    .s_apb_pready  (pready[0]),
    .s_apb_pslverr (pslverr[0]),
    .ctrl_o        (ctrl[0]),
    .status_i      (status),
    .irq_src_i     (irq_src),
    .irq_o         (irq[0])
  );

  intel_fpga_apb_csr #(.P_WAIT_STATES(3)) u_dut3 (
    .s_apb_pclk    (clk),
    .s_apb_presetn (rst_n),
    .s_apb_paddr   (paddr[1]),
    .s_apb_psel    (psel[1]),
    .s_apb_penable (penable[1]),
    .s_apb_pwrite  (pwrite[1]),
    .s_apb_pwdata  (pwdata[1]),
    .s_apb_prdata  (prdata[1]),
    .s_apb_pready  (pready[1]),
    .s_apb_pslverr (pslverr[1]),
    .ctrl_o        (ctrl[1]),
    .status_i      (status),
    .irq_src_i     (irq_src),
    .irq_o         (irq[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apb(input int d, input bit wr,
                     input logic [7:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err,
                     output int waits, output bit ok);
    waits = 0;
    ok    = 1'b0;
    rd    = '0;
    err   = 1'b0;
    @(posedge clk); #1;
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = a;
    pwdata[d]  = wd;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pready[d]) begin
        rd  = prdata[d];
        err = pslverr[d];
        ok  = 1'b1;
        break;
      end
      waits++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
  endtask

  // Reference model state.
  logic [31:0] m_scratch;
  logic [15:0] m_ctrl;
  logic [7:0]  m_en, m_pend, m_src;

  logic [31:0] rd, r1, exp_d;
  logic        err, exp_e;
  int          waits;
  bit          ok, wr;
  logic [7:0]  a, nsrc;
  logic [31:0] wd;
  logic [7:0]  addrs[8];

  initial begin
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < 2; i++) begin
      psel[i] = 0; penable[i] = 0; pwrite[i] = 0;
      paddr[i] = '0; pwdata[i] = '0;
    end
    status = '0;
    irq_src = '0;
    rst_n = 1'b0;
    m_scratch = '0; m_ctrl = '0; m_en = '0;
    m_pend = '0; m_src = '0;
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C,
              8'h10, 8'h14, 8'h40, 8'h24};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pready", pready[0], 0);
    chk("rst_prdata", prdata[0], 0);
    chk("rst_pslverr", pslverr[0], 0);
    chk("rst_ctrl", ctrl[0], 0);
    chk("rst_irq", irq[0], 0);
    rst_n = 1'b1;

    // Zero-wait write then read of SCRATCH.
    apb(0, 1, 8'h04, 32'hDEADBEEF, rd, err, waits, ok);
    m_scratch = 32'hDEADBEEF;
    chk("wr_done", ok, 1);
    chk("wr_waits", waits, 0);
    chk("wr_err", err, 0);
    apb(0, 0, 8'h04, 0, rd, err, waits, ok);
    chk("rd_waits", waits, 0);
    chk("rd_scratch", rd, 32'hDEADBEEF);

    // Three wait states on the second instance.
    apb(1, 0, 8'h00, 0, rd, err, waits, ok);
    chk("ws3_done", ok, 1);
    chk("ws3_waits", waits, 3);
    chk("ws3_id", rd, 32'h0A5B0001);
    chk("ws3_err", err, 0);

    // Interrupt edge latching and latency.
    apb(0, 1, 8'h14, 32'h1, rd, err, waits, ok);
    m_en = 8'h01;
    @(posedge clk); #1 irq_src = 8'h01;
    @(posedge clk);
    @(negedge clk);
    chk("irq_lat0", irq[0], 0);
    @(posedge clk);
    @(negedge clk);
    chk("irq_lat1", irq[0], 1);
    @(posedge clk); #1 irq_src = 8'h00;
    apb(0, 0, 8'h10, 0, rd, err, waits, ok);
    chk("pend_set", rd, 32'h1);

    // Clear and new edge in the same completion cycle.
    @(posedge clk); #1;
    psel[0] = 1; penable[0] = 0; pwrite[0] = 1;
    paddr[0] = 8'h10; pwdata[0] = 32'h1;
    @(posedge clk); #1;
    penable[0] = 1;
    irq_src = 8'h01;
    @(negedge clk);
    chk("w1c_rdy", pready[0], 1);
    @(posedge clk); #1;
    psel[0] = 0; penable[0] = 0;
    @(negedge clk);
    chk("setwin_irq_a", irq[0], 1);
    @(posedge clk);
    @(negedge clk);
    chk("setwin_irq_b", irq[0], 1);
    apb(0, 0, 8'h10, 0, rd, err, waits, ok);
    chk("setwin_pend", rd, 32'h1);

    // Plain clear with the source held high.
    apb(0, 1, 8'h10, 32'h1, rd, err, waits, ok);
    apb(0, 0, 8'h10, 0, rd, err, waits, ok);
    chk("w1c_pend", rd, 32'h0);
    chk("w1c_irq", irq[0], 0);
    m_src = 8'h01;

    // Counter advances one per clock.
    apb(0, 0, 8'h18, 0, r1, err, waits, ok);
    apb(0, 0, 8'h18, 0, rd, err, waits, ok);
    chk("cnt_step", rd - r1, 3);

    // Snapshot coherence across a rollover.
    force u_dut0.cnt_q = 64'h0000_0000_FFFF_FFFF;
    apb(0, 0, 8'h18, 0, rd, err, waits, ok);
    chk("cyc_lo", rd, 32'hFFFFFFFF);
    force u_dut0.cnt_q = 64'h0000_0001_0000_0000;
    apb(0, 0, 8'h1C, 0, rd, err, waits, ok);
    chk("cyc_hi", rd, 32'h0);
    force u_dut0.cnt_q = 64'h0000_0001_0000_0007;
    apb(0, 0, 8'h18, 0, rd, err, waits, ok);
    chk("cyc_lo2", rd, 32'h7);
    apb(0, 0, 8'h1C, 0, rd, err, waits, ok);
    chk("cyc_hi2", rd, 32'h1);
    release u_dut0.cnt_q;

    // Unmapped and read-only accesses.
    apb(0, 0, 8'h40, 0, rd, err, waits, ok);
    chk("unm_rd", rd, 0);
    chk("unm_rd_err", err, 1);
    apb(0, 1, 8'h40, 32'h12345678, rd, err, waits, ok);
    chk("unm_wr_err", err, 1);
    apb(0, 1, 8'h44, 32'h55, rd, err, waits, ok);
    chk("unm_wr_err2", err, 1);
    apb(0, 0, 8'h04, 0, rd, err, waits, ok);
    chk("unm_keep", rd, m_scratch);
    apb(0, 1, 8'h00, 32'h0, rd, err, waits, ok);
    chk("ro_wr_err", err, 0);
    apb(0, 0, 8'h00, 0, rd, err, waits, ok);
    chk("ro_keep", rd, 32'h0A5B0001);

    // Randomized traffic against the model.
    for (int it = 0; it < 40; it++) begin
      nsrc = 8'($urandom);
      @(posedge clk); #1;
      irq_src = nsrc;
      status = $urandom;
      m_pend = m_pend | (nsrc & ~m_src);
      m_src = nsrc;
      a = addrs[$urandom_range(0, 7)];
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      apb(0, wr, a, wd, rd, err, waits, ok);
      exp_e = (a >= 8'h20);
      exp_d = '0;
      if (wr) begin
        case (a)
          8'h04: m_scratch = wd;
          8'h08: m_ctrl = wd[15:0];
          8'h10: m_pend = m_pend & ~wd[7:0];
          8'h14: m_en = wd[7:0];
          default: ;
        endcase
      end else begin
        case (a)
          8'h00: exp_d = 32'h0A5B0001;
          8'h04: exp_d = m_scratch;
          8'h08: exp_d = {16'h0, m_ctrl};
          8'h0C: exp_d = status;
          8'h10: exp_d = {24'h0, m_pend};
          8'h14: exp_d = {24'h0, m_en};
          default: exp_d = '0;
        endcase
        chk($sformatf("rnd%0d_rd_%0h", it, a), rd, exp_d);
      end
      chk($sformatf("rnd%0d_err_%0h", it, a), err, exp_e);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rnd%0d_irq", it), irq[0], |(m_pend & m_en));
      chk($sformatf("rnd%0d_ctrl", it), ctrl[0], m_ctrl);
    end

    // Reset during the access phase of a CONTROL write.
    apb(0, 1, 8'h08, 32'hA5A5, rd, err, waits, ok);
    chk("pre_rst_ctrl", ctrl[0], 16'hA5A5);
    @(posedge clk); #1;
    psel[0] = 1; penable[0] = 0; pwrite[0] = 1;
    paddr[0] = 8'h08; pwdata[0] = 32'h1234;
    @(posedge clk); #1;
    penable[0] = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", ctrl[0], 0);
    chk("midrst_pready", pready[0], 0);
    @(posedge clk); #1;
    psel[0] = 0; penable[0] = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    apb(0, 0, 8'h08, 0, rd, err, waits, ok);
    chk("postrst_ctrl", rd, 0);
    apb(0, 0, 8'h04, 0, rd, err, waits, ok);
    chk("postrst_scratch", rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
